// File: rtl/block_serial_subtractor.sv
// Purpose: multi-cycle unsigned subtractor, d = a - b - bin, one BLOCK_LEN slice per cycle.
// Latency: out_valid rises NBLK cycles after the accepting edge; issue interval NBLK+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Optional ovf port: SUB_OVERFLOW_EN.
module block_serial_subtractor #(
  parameter int INPUT_LEN = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INPUT_LEN-1:0] a,
  input  logic [INPUT_LEN-1:0] b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INPUT_LEN-1:0] d,
  output logic                 bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic                 ovf
`endif
);

  // Guarded so a bad BLOCK_LEN reaches the elaboration error instead of a divide-by-zero.
  localparam int NBLK = (BLOCK_LEN > 0) ? (INPUT_LEN / BLOCK_LEN) : 1;
  localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  if (BLOCK_LEN < 1) begin : g_bad_block_len
    $error("block_serial_subtractor: BLOCK_LEN must be at least 1");
  end else if ((INPUT_LEN % BLOCK_LEN) != 0) begin : g_bad_ratio
    $error("block_serial_subtractor: INPUT_LEN must be a multiple of BLOCK_LEN");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [INPUT_LEN-1:0] a_r;
  logic [INPUT_LEN-1:0] b_r;
  logic                 borrow;
  logic [BLOCK_LEN-1:0] a_sl;
  logic [BLOCK_LEN-1:0] b_sl;
  logic [BLOCK_LEN:0]   sum_sl;
  logic                 last_slice;

  // Reset dominates so no operands are accepted while rst is asserted.
  assign in_ready   = (state == IDLE) && !rst;
  assign last_slice = (cnt == CW'(NBLK - 1));

  // Select the captured operand slice addressed by the slice counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_r[k*BLOCK_LEN +: BLOCK_LEN];
        b_sl = b_r[k*BLOCK_LEN +: BLOCK_LEN];
      end
    end
  end

  // Subtraction as a + ~b + carry, where carry-in is the inverted borrow; MSB is carry out.
  assign sum_sl = {1'b0, a_sl} + {1'b0, ~b_sl} + {{BLOCK_LEN{1'b0}}, ~borrow};

`ifdef SUB_OVERFLOW_EN
  logic carry_into_msb;
  // Carry into the top bit recovered from its sum bit and the two addend bits.
  assign carry_into_msb = sum_sl[BLOCK_LEN-1] ^ a_sl[BLOCK_LEN-1] ^ ~b_sl[BLOCK_LEN-1];
`endif

  // Control FSM plus datapath registers: capture, slice-per-cycle run, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      borrow    <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NBLK; k++) begin
            if (cnt == CW'(k)) begin
              d[k*BLOCK_LEN +: BLOCK_LEN] <= sum_sl[BLOCK_LEN-1:0];
            end
          end
          borrow <= ~sum_sl[BLOCK_LEN];
          if (last_slice) begin
            bout      <= ~sum_sl[BLOCK_LEN];
`ifdef SUB_OVERFLOW_EN
            ovf       <= carry_into_msb ^ sum_sl[BLOCK_LEN];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Bench for block_serial_subtractor at INPUT_LEN=16, BLOCK_LEN=4.
// Directed corner cases plus randomized operands against an arithmetic reference.
// Covers reset, result hold under backpressure, mid-run reset and back-to-back issue.
module tb_block_serial_subtractor;
  localparam int N  = 16;
  localparam int BL = 4;
  localparam int NB = N / BL;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  block_serial_subtractor #(.INPUT_LEN(N), .BLOCK_LEN(BL)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d(d),
    .bout(bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: full-precision subtraction; bit N is the borrow.
  function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, c};
  endfunction

  // Reference: signed result outside the N-bit two's complement range.
  function automatic logic ref_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    int sx;
    int sy;
    int ci;
    int r;
    sx = $signed(x);
    sy = $signed(y);
    ci = c;
    r  = sx - sy - ci;
    return (r > 32767) || (r < -32768);
  endfunction

  // Offer one operand set (called at a negedge); scrambles inputs right after the accept edge.
  task automatic accept_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    in_valid = 1'b1;
    a = xa;
    b = xb;
    bin = xc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    bin = 1'($urandom);
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    bit seen;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1 after %0d", out_valid, lat, NB);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_d: got %h required 0000", d); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout: got %b required 0", bout); end
`ifdef SUB_OVERFLOW_EN
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b required 0", ovf); end
`endif
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    accept_op(16'h1234, 16'h0234, 1'b0);
    wait_result(lat);
    n_cmp++; if (d !== 16'h1000) begin n_bad++; $display("FAIL dir1_d: got %h required 1000", d); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL dir1_bout: got %b required 0", bout); end
    n_cmp++; if (lat !== NB) begin n_bad++; $display("FAIL dir1_latency: got %0d required %0d", lat, NB); end
    consume();

    accept_op(16'h0000, 16'h0001, 1'b0);
    wait_result(lat);
    n_cmp++; if (d !== 16'hFFFF) begin n_bad++; $display("FAIL dir2_d: got %h required ffff", d); end
    n_cmp++; if (bout !== 1'b1) begin n_bad++; $display("FAIL dir2_bout: got %b required 1", bout); end
`ifdef SUB_OVERFLOW_EN
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL dir2_ovf: got %b required 0", ovf); end
`endif
    consume();

`ifdef SUB_OVERFLOW_EN
    accept_op(16'h8000, 16'h0001, 1'b0);
    wait_result(lat);
    n_cmp++; if (d !== 16'h7FFF) begin n_bad++; $display("FAIL dir3_d: got %h required 7fff", d); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL dir3_bout: got %b required 0", bout); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL dir3_ovf: got %b required 1", ovf); end
    consume();
`endif
  endtask

  task automatic test_hold();
    int lat;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N:0] exp;
    x = N'($urandom);
    y = N'($urandom);
    exp = ref_sub(x, y, 1'b1);
    accept_op(x, y, 1'b1);
    wait_result(lat);
    n_cmp++; if (d !== exp[N-1:0]) begin n_bad++; $display("FAIL hold_initial_d: got %h required %h", d, exp[N-1:0]); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = N'($urandom);
      b = N'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (d !== exp[N-1:0]) begin n_bad++; $display("FAIL hold_d cycle %0d: got %h required %h", i, d, exp[N-1:0]); end
      n_cmp++; if (bout !== exp[N]) begin n_bad++; $display("FAIL hold_bout cycle %0d: got %b required %b", i, bout, exp[N]); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready cycle %0d: got %b required 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_out_valid cycle %0d: got %b required 1", i, out_valid); end
    end
    in_valid = 1'b0;
    consume();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_out_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    accept_op(16'hFFFF, 16'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_in_ready: got %b required 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL midrun_d: got %h required 0000", d); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL midrun_bout: got %b required 0", bout); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrun_in_ready: got %b required 1", in_ready); end
    accept_op(16'h0005, 16'h0005, 1'b1);
    wait_result(lat);
    n_cmp++; if (d !== 16'hFFFF) begin n_bad++; $display("FAIL midrun_next_d: got %h required ffff", d); end
    n_cmp++; if (bout !== 1'b1) begin n_bad++; $display("FAIL midrun_next_bout: got %b required 1", bout); end
    n_cmp++; if (lat !== NB) begin n_bad++; $display("FAIL midrun_next_latency: got %0d required %0d", lat, NB); end
    consume();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int lat;
      int sel;
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic c;
      logic [N:0] exp;
      sel = $urandom_range(0, 4);
      x = N'($urandom);
      y = N'($urandom);
      c = 1'($urandom);
      if (sel == 1) y = x;
      if (sel == 2) x = '0;
      if (sel == 3) begin x = 16'h8000; y = N'($urandom_range(0, 3)); end
      if (sel == 4) begin x = 16'h7FFF; y = 16'hFFFF; end
      exp = ref_sub(x, y, c);
      accept_op(x, y, c);
      wait_result(lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
      end
      n_cmp++; if (d !== exp[N-1:0]) begin n_bad++; $display("FAIL rand_d op %0d (%h-%h-%b): got %h required %h", i, x, y, c, d, exp[N-1:0]); end
      n_cmp++; if (bout !== exp[N]) begin n_bad++; $display("FAIL rand_bout op %0d (%h-%h-%b): got %b required %b", i, x, y, c, bout, exp[N]); end
      n_cmp++; if (lat !== NB) begin n_bad++; $display("FAIL rand_latency op %0d: got %0d required %0d", i, lat, NB); end
`ifdef SUB_OVERFLOW_EN
      n_cmp++; if (ovf !== ref_ovf(x, y, c)) begin n_bad++; $display("FAIL rand_ovf op %0d (%h-%h-%b): got %b required %b", i, x, y, c, ovf, ref_ovf(x, y, c)); end
`endif
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [N:0] exp_q[$];
    logic       ovf_q[$];
    int         acc_cyc[$];
    int         nacc;
    int         nres;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic c;
    logic [N:0] e;
    logic eo;
    nacc = 0;
    nres = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b2b_extra_result: got d=%h with no operation outstanding, required none", d);
        end else begin
          e = exp_q.pop_front();
          eo = ovf_q.pop_front();
          nres++;
          n_cmp++; if (d !== e[N-1:0]) begin n_bad++; $display("FAIL b2b_d result %0d: got %h required %h", nres, d, e[N-1:0]); end
          n_cmp++; if (bout !== e[N]) begin n_bad++; $display("FAIL b2b_bout result %0d: got %b required %b", nres, bout, e[N]); end
`ifdef SUB_OVERFLOW_EN
          n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL b2b_ovf result %0d: got %b required %b", nres, ovf, eo); end
`endif
        end
      end
      x = N'($urandom);
      y = N'($urandom);
      c = 1'($urandom);
      a = x;
      b = y;
      bin = c;
      in_valid = (nacc < 10);
      if (in_ready && nacc < 10) begin
        exp_q.push_back(ref_sub(x, y, c));
        ovf_q.push_back(ref_ovf(x, y, c));
        acc_cyc.push_back(cyc);
        nacc++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (nres !== 10) begin n_bad++; $display("FAIL b2b_result_count: got %0d required 10", nres); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_cmp++;
      if (acc_cyc[i] - acc_cyc[i-1] !== NB + 2) begin
        n_bad++;
        $display("FAIL b2b_issue_interval %0d: got %0d required %0d", i, acc_cyc[i] - acc_cyc[i-1], NB + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
